// File: rtl/id_ex_skid_stage_if.sv
// Decode-to-execute handshake bundle for the ID/EX stage: upstream payload,
// downstream payload, flush and occupancy.
interface id_ex_skid_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CTRL_W = 7
);
    logic              up_valid_i;
    logic              up_ready_o;
    logic [ADDR_W-1:0] up_pc_i;
    logic [DATA_W-1:0] up_data1_i;
    logic [DATA_W-1:0] up_data2_i;
    logic [REG_W-1:0]  up_reg3_i;
    logic [DATA_W-1:0] up_inst_i;
    logic [CTRL_W-1:0] up_ctrl_i;
    logic              flush_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [ADDR_W-1:0] dn_pc_o;
    logic [DATA_W-1:0] dn_data1_o;
    logic [DATA_W-1:0] dn_data2_o;
    logic [REG_W-1:0]  dn_reg3_o;
    logic [DATA_W-1:0] dn_inst_o;
    logic [CTRL_W-1:0] dn_ctrl_o;
    logic [1:0]        occupancy_o;

    modport master (
        output up_valid_i, up_pc_i, up_data1_i, up_data2_i, up_reg3_i,
               up_inst_i, up_ctrl_i, flush_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, dn_pc_o, dn_data1_o, dn_data2_o,
               dn_reg3_o, dn_inst_o, dn_ctrl_o, occupancy_o
    );

    modport slave (
        input  up_valid_i, up_pc_i, up_data1_i, up_data2_i, up_reg3_i,
               up_inst_i, up_ctrl_i, flush_i, dn_ready_i,
        output up_ready_o, dn_valid_o, dn_pc_o, dn_data1_o, dn_data2_o,
               dn_reg3_o, dn_inst_o, dn_ctrl_o, occupancy_o
    );
endinterface

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with valid/ready handshake, optional one-entry skid
// buffer, synchronous flush and bubble forcing of the control vector.
module id_ex_skid_stage #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int CTRL_W  = 7,
    parameter int SKID_EN = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    id_ex_skid_stage_if.slave  bus
);
    localparam int PAY_W = ADDR_W + 3*DATA_W + REG_W + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             state_p1;
    logic [PAY_W-1:0]   pay_p0;
    logic [PAY_W-1:0]   main_p1;
    logic [PAY_W-1:0]   skid_p1;
    logic [CTRL_W-1:0]  main_ctrl;
    logic               dn_valid;
    logic               up_ready;
    logic               accept;
    logic               retire;

    assign pay_p0 = {bus.up_pc_i, bus.up_data1_i, bus.up_data2_i,
                     bus.up_reg3_i, bus.up_inst_i, bus.up_ctrl_i};

    assign dn_valid = (state_p1 != EMPTY);

    // With the skid buffer, ready depends only on registered state; without it,
    // ready passes dn_ready_i straight through so a held entry can be replaced.
    assign up_ready = ~rst_i & ((SKID_EN != 0) ? (state_p1 != SKID)
                                               : (~dn_valid | bus.dn_ready_i));

    assign accept = bus.up_valid_i & up_ready;
    assign retire = dn_valid & bus.dn_ready_i;

    // Stage boundary: decode payload -> main/skid entries
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p1 <= EMPTY;
            main_p1  <= '0;
            skid_p1  <= '0;
        end else if (bus.flush_i) begin
            state_p1 <= EMPTY;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (accept) begin
                        main_p1  <= pay_p0;
                        state_p1 <= FULL;
                    end
                end
                FULL: begin
                    if (accept && retire) begin
                        main_p1 <= pay_p0;
                    end else if (retire) begin
                        state_p1 <= EMPTY;
                    end else if (accept && (SKID_EN != 0)) begin
                        skid_p1  <= pay_p0;
                        state_p1 <= SKID;
                    end
                end
                SKID: begin
                    if (retire) begin
                        main_p1  <= skid_p1;
                        state_p1 <= FULL;
                    end
                end
                default: state_p1 <= EMPTY;
            endcase
        end
    end

    assign {bus.dn_pc_o, bus.dn_data1_o, bus.dn_data2_o,
            bus.dn_reg3_o, bus.dn_inst_o, main_ctrl} = main_p1;

    // A stale entry must never drive regWrite/memWrite into execute.
    assign bus.dn_ctrl_o   = dn_valid ? main_ctrl : '0;
    assign bus.dn_valid_o  = dn_valid;
    assign bus.up_ready_o  = up_ready;
    assign bus.occupancy_o = state_p1;
endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised ID/EX pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
- Carries PC, two operands, destination register, instruction word and a control-bit vector from decode to execute.
- Adds per-stage backpressure, synchronous flush for branch/jump squash, and bubble forcing of control bits whenever no valid instruction is presented.
- Sits between the decode and execute units and replaces the plain always-load ID/EX register.

Parameters:
- ADDR_W, 16, PC width
- DATA_W, 16, operand and instruction width
- REG_W, 3, destination register index width
- CTRL_W, 7, control vector width; bits in order: [0] jump, [1] immOrReg, [2] branch, [3] resultOrMem, [4] memRead, [5] memWrite, [6] regWrite
- SKID_EN, 1, 1 = two-entry (main + skid); 0 = single entry, up_ready_o combinationally depends on dn_ready_i

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- up_valid_i  in  1  decode presents an instruction
- up_ready_o  out  1  stage can accept this cycle
- up_pc_i  in  ADDR_W  decode PC
- up_data1_i  in  DATA_W  operand 1
- up_data2_i  in  DATA_W  operand 2
- up_reg3_i  in  REG_W  destination register
- up_inst_i  in  DATA_W  instruction word
- up_ctrl_i  in  CTRL_W  control vector
- flush_i  in  1  squash all held entries (synchronous)
- dn_valid_o  out  1  execute sees a valid instruction
- dn_ready_i  in  1  execute consumes this cycle
- dn_pc_o  out  ADDR_W  registered PC
- dn_data1_o  out  DATA_W  registered operand 1
- dn_data2_o  out  DATA_W  registered operand 2
- dn_reg3_o  out  REG_W  registered destination register
- dn_inst_o  out  DATA_W  registered instruction word
- dn_ctrl_o  out  CTRL_W  control vector; forced to 0 when dn_valid_o = 0
- occupancy_o  out  2  entries held (0..2)

Behaviour:
- Reset (rst_i = 1, asynchronous): all outputs and internal regs are 0. up_ready_o = 1 from reset release onward.
- Handshake definitions:
  - Accept = up_valid_i & up_ready_o.
  - Retire = dn_valid_o & dn_ready_i.
  - Payload is captured only on accept; it is never loaded speculatively.
- State machine for SKID_EN = 1 (state is registered; outputs come directly from the main register):
  - EMPTY:
    - dn_valid_o = 0; up_ready_o = 1.
    - accept -> FULL, loading main.
  - FULL:
    - dn_valid_o = 1; up_ready_o = 1.
    - accept & retire -> FULL, main reloaded.
    - retire only -> EMPTY.
    - accept only -> SKID, payload into the skid register.
  - SKID:
    - up_ready_o = 0, registered, so there is no combinational ready path.
    - retire -> FULL, skid moved to main.
- SKID_EN = 0: up_ready_o = ~dn_valid_o | dn_ready_i. SKID state is unreachable.
- Latency: 1 cycle accept-to-dn_valid_o when EMPTY. Throughput is 1 instruction per cycle with dn_ready_i held high.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- flush_i:
  - The next state is EMPTY regardless of accept or retire in the same cycle; flush has priority and the incoming instruction is dropped.
  - Data fields hold their last values; dn_ctrl_o reads 0 through the bubble rule.
  - up_ready_o = 1 in the cycle after flush.
- Bubble rule: dn_ctrl_o = main_ctrl when dn_valid_o = 1, else all-zero. This guarantees no regWrite/memWrite side effects from a stale entry.
- occupancy_o: EMPTY = 0, FULL = 1, SKID = 2.
- Reset asserted mid-transfer: every entry is lost immediately and no partial payload survives.
- Assertion for the bench: dn_* payload is stable while dn_valid_o = 1 and dn_ready_i = 0.

Test Plan:
- Reset check: assert rst_i asynchronously mid-cycle with the stage in SKID -> dn_valid_o = 0, dn_ctrl_o = 0, occupancy_o = 0 immediately; up_ready_o = 1 after release.
- Streaming: feed PC 0x0000..0x0007 back-to-back with dn_ready_i = 1 -> dn_pc_o shows 0x0000..0x0007 on consecutive cycles, 1-cycle latency, occupancy_o = 1 throughout.
- Backpressure: dn_ready_i = 0 while sending PC 0x0010 and 0x0012 -> occupancy_o = 2 and up_ready_o = 0. Raise dn_ready_i -> outputs 0x0010 then 0x0012, with no loss or duplication.
- Flush with accept: state SKID, up_valid_i = 1 with PC 0x0020, flush_i = 1 -> next cycle dn_valid_o = 0, dn_ctrl_o = 7'b0, occupancy_o = 0; PC 0x0020 never appears.
- Bubble on stale data: retire the last instruction, which had ctrl = 7'b1100000 -> next cycle dn_ctrl_o = 0 while dn_inst_o still holds the old word.
- SKID_EN = 0 build: dn_ready_i = 0 with one entry held -> up_ready_o = 0. Set dn_ready_i = 1 and up_valid_i = 1 in the same cycle -> simultaneous replace, occupancy_o stays 1.
